// File: rtl/alu_mul_sequencer.sv
// Shift-add multiply sequencer that borrows the shared ALU's ADDU operation
// one bit per cycle, arbitrating the ALU away from the EX-stage pipeline.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   start_i                  launch a multiply (sampled in IDLE only)
//   mul_src1_i, mul_src2_i   multiplicand, multiplier
//   pipe_src1_i/src2_i/ctrl_i  EX-stage ALU request
//   pipe_gnt_o, busy_o       pipeline owns ALU / pipeline must stall
//   alu_src1_o/src2_o/ctrl_o ALU request, alu_result_i ALU answer
//   done_o, result_o         one-cycle done pulse, low WIDTH product bits
module alu_mul_sequencer #(
  parameter int         WIDTH      = 32,
  parameter logic [3:0] ADDU_CTRL  = 4'd4,
  parameter bit         EARLY_EXIT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] mul_src1_i,
  input  logic [WIDTH-1:0] mul_src2_i,
  input  logic [WIDTH-1:0] pipe_src1_i,
  input  logic [WIDTH-1:0] pipe_src2_i,
  input  logic [3:0]       pipe_ctrl_i,
  output logic             pipe_gnt_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] alu_src1_o,
  output logic [WIDTH-1:0] alu_src2_o,
  output logic [3:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] result_q;
  logic [5:0]       step_q;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mplier_shr;
  logic             last_step;

  // Accumulate only when the current multiplier bit is set.
  assign acc_nxt    = mplier_q[0] ? alu_result_i : acc_q;
  assign mplier_shr = mplier_q >> 1;
  assign last_step  = (step_q == LAST_STEP) ||
                      (EARLY_EXIT && (mplier_shr == '0));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pipe_gnt_o = 1'b1;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    alu_src1_o = pipe_src1_i;
    alu_src2_o = pipe_src2_i;
    alu_ctrl_o = pipe_ctrl_i;
    unique case (state_q)
      IDLE: ;
      RUN: begin
        pipe_gnt_o = 1'b0;
        busy_o     = 1'b1;
        alu_src1_o = acc_q;
        alu_src2_o = mcand_q;
        alu_ctrl_o = ADDU_CTRL;
      end
      DONE: begin
        pipe_gnt_o = 1'b0;
        busy_o     = 1'b1;
        done_o     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      step_q   <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= mul_src1_i;
            mplier_q <= mul_src2_i;
            step_q   <= '0;
          end
        end
        RUN: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_shr;
          step_q   <= step_q + 6'd1;
          // Capture includes the final accumulate of this cycle.
          if (last_step) result_q <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign result_o = result_q;

endmodule
